angle_scan_ctrl: RTL and testbench
==================================

// Module: angle_scan_ctrl
// PURPOSE
//  Controller for the 256-entry angle_buffer. Owns the write pointer/fill count and sequences read scans for select_eps.
//  A scan reads the last scan_len angles oldest-first, one address per rd_valid/rd_ready handshake.
//  Flags overrun when a concurrent write overwrites an unread window entry.
//  Sits between the angle module (write side), angle_buffer (storage) and select_eps (scan requester/consumer).
// PARAMETERS
//  DEPTH  256  buffer entries; power of two
//  AW     8    address width = log2(DEPTH)
//  LW     9    length/count width = AW+1 (holds DEPTH)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, asynchronous, active-high
//  frame_start  in   1   pulse: new frame; clears pointer/fill, aborts any scan
//  angle_valid  in   1   new angle sample present this cycle
//  buf_wr_en    out  1   write strobe to angle_buffer (combinational = angle_valid)
//  buf_wr_addr  out  AW  write address (combinational: frame_start ? 0 : wr_ptr)
//  wr_ptr       out  AW  registered next-write address
//  fill_cnt     out  LW  valid entries since frame_start, saturates at DEPTH
//  scan_req     in   1   request a scan; level, held until scan_ack or scan_err
//  scan_len     in   LW  window length; sampled when scan_req is accepted
//  scan_ack     out  1   1-cycle pulse: request accepted
//  scan_err     out  1   1-cycle pulse: request rejected (len 0 or len > fill_cnt)
//  rd_addr      out  AW  scan read address
//  rd_valid     out  1   rd_addr valid
//  rd_ready     in   1   consumer accepts rd_addr this cycle
//  rd_last      out  1   current rd_addr is the final one of the scan
//  scan_done    out  1   1-cycle pulse, cycle after the last handshake
//  overrun      out  1   sticky: unread window entry overwritten; cleared by frame_start
//  busy         out  1   state == SCAN
// BEHAVIOUR
//  Reset: wr_ptr=0, fill_cnt=0, state IDLE; every registered output 0.
//  Write side: independent of the FSM; never stalls the angle module.
//   - angle_valid & !frame_start: wr_ptr<=wr_ptr+1 (mod DEPTH); fill_cnt<=min(fill_cnt+1,DEPTH).
//   - frame_start: buf_wr_addr=0; wr_ptr<=angle_valid; fill_cnt<=angle_valid; overrun<=0.
//     Same-cycle sample is entry 0 of the new frame.
//  FSM (IDLE, ACTIVE, SCAN, DONE):
//   - IDLE: fill_cnt==0 -> IDLE. Any write moves to ACTIVE next cycle.
//   - ACTIVE: scan_req sampled here only.
//     - len==0 or len>fill_cnt: scan_err pulse next cycle; stay ACTIVE.
//     - Otherwise: scan_ack pulse next cycle; capture start=wr_ptr-len (mod DEPTH) and rem=len; go SCAN.
//     - wr_ptr/fill_cnt compare against values before this cycle's write.
//     - scan_req in IDLE/SCAN/DONE is ignored (no ack, no err).
//   - SCAN: rd_valid=1 and rd_addr=current address.
//     - On rd_valid&rd_ready: address+1 (mod DEPTH), rem-1.
//     - rd_last = (rem==1). Handshake with rd_last -> DONE.
//     - rd_addr holds while rd_ready=0.
//   - DONE: scan_done=1 for one cycle; rd_valid=0; -> ACTIVE.
//   - frame_start in any state -> IDLE next cycle (ACTIVE if same-cycle write). rd_valid drops; no scan_done.
//  Latency: request accepted in cycle N -> scan_ack and first rd_valid in N+1.
//   - Zero-stall scan of L takes L cycles, scan_done at N+1+L.
//  Overrun: wcnt counts writes since accept; rcnt counts completed reads.
//   - overrun<=1 when a write occurs while SCAN and wcnt >= DEPTH-len+rcnt (write would hit an unread entry).
//   - The scan still completes; data integrity is the consumer's concern.
//  Wrap-around: all address arithmetic is mod DEPTH; len==DEPTH valid only when fill_cnt==DEPTH (start=wr_ptr).
//  Outputs rd_*, scan_*, busy are registered or decoded from registered state only; no comb path from rd_ready.
// STRUCTURE
//  Shared package (data_type.svh): ANG_BUF_DEPTH, ANG_BUF_AW, ANG_BUF_LW, typedef scan_state_e {IDLE,ACTIVE,SCAN,DONE}.
//  ang_t is unchanged.
//  One sub-module: angle_scan_agen (start/rem/addr counters, rd_last), driven by the FSM's load/advance strobes.
// TESTING
//  1 Reset mid-scan: assert rst while rd_valid=1 -> all outputs 0 same cycle, state IDLE after release.
//  2 Fill 10 samples, scan_req len=4, rd_ready=1 -> ack next cycle; rd_addr 6,7,8,9; rd_last on 9; scan_done 1 cycle later.
//  3 Requests len=0, len=11 with fill=10 -> scan_err pulse each; no ack; busy stays 0.
//  4 Write 300 samples (wr_ptr=44, fill=256), scan len=256 -> rd_addr 44..255,0..43; fill stays 256.
//  5 Backpressure: rd_ready toggling 1,0,0,1 during len=3 scan -> rd_addr stable while low; 3 handshakes then scan_done.
//  6 Scan len=256 with rd_ready=0 while 1 write occurs -> overrun=1.
//    Then frame_start with angle_valid=1 -> buf_wr_addr=0, wr_ptr=1, fill=1, overrun=0, rd_valid=0, no scan_done.

Source files
------------

// File: rtl/angle_scan_ctrl_pkg.sv
// Shared sizing and state encoding for the angle buffer scan controller.
package angle_scan_ctrl_pkg;

   localparam int ANG_BUF_DEPTH = 256;
   localparam int ANG_BUF_AW    = $clog2(ANG_BUF_DEPTH);
   localparam int ANG_BUF_LW    = ANG_BUF_AW + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      SCAN   = 2'd2,
      DONE   = 2'd3
   } scan_state_e;

endpackage

// File: rtl/angle_scan_agen.sv
// Scan address generator: loads the window start and remaining count, then
// steps one address per accepted read.
module angle_scan_agen
   import angle_scan_ctrl_pkg::*;
#(
   parameter int AW = ANG_BUF_AW,
   parameter int LW = ANG_BUF_LW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_i,
   input  logic          advance_i,
   input  logic [AW-1:0] wr_ptr_i,
   input  logic [LW-1:0] len_i,
   output logic [AW-1:0] addr_o,
   output logic [LW-1:0] rem_o,
   output logic          last_o
);

   logic [AW-1:0] addr_q;
   logic [LW-1:0] rem_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= '0;
         rem_q  <= '0;
      end else if (load_i) begin
         // A full-depth window truncates to 0 here, so it starts at wr_ptr.
         addr_q <= wr_ptr_i - len_i[AW-1:0];
         rem_q  <= len_i;
      end else if (advance_i) begin
         addr_q <= addr_q + AW'(1);
         rem_q  <= rem_q - LW'(1);
      end
   end

   assign addr_o = addr_q;
   assign rem_o  = rem_q;
   assign last_o = (rem_q == LW'(1));

endmodule

// File: rtl/angle_scan_ctrl.sv
// Angle buffer controller: free-running write pointer/fill count plus an
// oldest-first read scan sequencer for the endpoint selector.
//
//   state  | meaning
//   IDLE   | buffer empty since frame start
//   ACTIVE | samples present, scan requests accepted
//   SCAN   | issuing read addresses, one per rd handshake
//   DONE   | scan_done pulse, back to ACTIVE
module angle_scan_ctrl
   import angle_scan_ctrl_pkg::*;
#(
   parameter int DEPTH = ANG_BUF_DEPTH,
   parameter int AW    = ANG_BUF_AW,
   parameter int LW    = ANG_BUF_LW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          frame_start_i,
   input  logic          angle_valid_i,
   output logic          buf_wr_en_o,
   output logic [AW-1:0] buf_wr_addr_o,
   output logic [AW-1:0] wr_ptr_o,
   output logic [LW-1:0] fill_cnt_o,
   input  logic          scan_req_i,
   input  logic [LW-1:0] scan_len_i,
   output logic          scan_ack_o,
   output logic          scan_err_o,
   output logic [AW-1:0] rd_addr_o,
   output logic          rd_valid_o,
   input  logic          rd_ready_i,
   output logic          rd_last_o,
   output logic          scan_done_o,
   output logic          overrun_o,
   output logic          busy_o
);

   scan_state_e   state_q;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [LW-1:0] fill_cnt_q, fill_cnt_d;
   logic [LW-1:0] wcnt_q;
   logic          overrun_q, scan_ack_q, scan_err_q;
   logic          wr_fire, len_ok, load, advance;
   logic [AW-1:0] agen_addr;
   logic [LW-1:0] agen_rem;
   logic          agen_last;

   assign wr_fire       = angle_valid_i & ~frame_start_i;
   assign buf_wr_en_o   = angle_valid_i;
   assign buf_wr_addr_o = frame_start_i ? '0 : wr_ptr_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      fill_cnt_d = fill_cnt_q;
      if (frame_start_i) begin
         wr_ptr_d   = AW'(angle_valid_i);
         fill_cnt_d = LW'(angle_valid_i);
      end else if (angle_valid_i) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (fill_cnt_q != LW'(DEPTH))
            fill_cnt_d = fill_cnt_q + LW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         fill_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         fill_cnt_q <= fill_cnt_d;
      end
   end

   // A request still held during its own err pulse is not re-evaluated.
   assign len_ok  = (scan_len_i != '0) && (scan_len_i <= fill_cnt_q);
   assign load    = (state_q == ACTIVE) && !frame_start_i && scan_req_i && !scan_err_q && len_ok;
   assign advance = (state_q == SCAN) && rd_ready_i && !frame_start_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         scan_ack_q <= 1'b0;
         scan_err_q <= 1'b0;
         overrun_q  <= 1'b0;
         wcnt_q     <= '0;
      end else begin
         scan_ack_q <= 1'b0;
         scan_err_q <= 1'b0;
         if (wr_fire && wcnt_q != LW'(DEPTH))
            wcnt_q <= wcnt_q + LW'(1);
         if (frame_start_i) begin
            state_q   <= angle_valid_i ? ACTIVE : IDLE;
            overrun_q <= 1'b0;
         end else begin
            // rem = len - reads done, so writes may safely reach DEPTH - rem.
            if (state_q == SCAN && wr_fire && wcnt_q >= LW'(DEPTH) - agen_rem)
               overrun_q <= 1'b1;
            unique case (state_q)
               IDLE:    if (angle_valid_i) state_q <= ACTIVE;
               ACTIVE:  if (scan_req_i && !scan_err_q) begin
                           if (len_ok) begin
                              scan_ack_q <= 1'b1;
                              wcnt_q     <= '0;
                              state_q    <= SCAN;
                           end else begin
                              scan_err_q <= 1'b1;
                           end
                        end
               SCAN:    if (advance && agen_last) state_q <= DONE;
               DONE:    state_q <= ACTIVE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   angle_scan_agen #(
      .AW (AW),
      .LW (LW)
   ) u_agen (
      .clk       (clk),
      .rst       (rst),
      .load_i    (load),
      .advance_i (advance),
      .wr_ptr_i  (wr_ptr_q),
      .len_i     (scan_len_i),
      .addr_o    (agen_addr),
      .rem_o     (agen_rem),
      .last_o    (agen_last)
   );

   assign wr_ptr_o    = wr_ptr_q;
   assign fill_cnt_o  = fill_cnt_q;
   assign scan_ack_o  = scan_ack_q;
   assign scan_err_o  = scan_err_q;
   assign overrun_o   = overrun_q;
   assign rd_addr_o   = agen_addr;
   assign rd_valid_o  = (state_q == SCAN);
   assign busy_o      = (state_q == SCAN);
   assign rd_last_o   = (state_q == SCAN) && agen_last;
   assign scan_done_o = (state_q == DONE);

endmodule

// File: tb/tb_angle_scan_ctrl.sv
// Self-checking bench for angle_scan_ctrl: reference write-pointer model and
// a queue of expected read addresses consumed on each rd handshake.
module tb_angle_scan_ctrl;

   logic       clk;
   logic       rst;
   logic       frame_start, angle_valid;
   logic       buf_wr_en;
   logic [7:0] buf_wr_addr, wr_ptr;
   logic [8:0] fill_cnt;
   logic       scan_req;
   logic [8:0] scan_len;
   logic       scan_ack, scan_err;
   logic [7:0] rd_addr;
   logic       rd_valid, rd_ready, rd_last, scan_done, overrun, busy;

   int         n_vec  = 0;
   int         n_miss = 0;
   int         m_wr   = 0;
   int         m_fill = 0;
   logic [7:0] exp_q[$];

   angle_scan_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .frame_start_i (frame_start),
      .angle_valid_i (angle_valid),
      .buf_wr_en_o   (buf_wr_en),
      .buf_wr_addr_o (buf_wr_addr),
      .wr_ptr_o      (wr_ptr),
      .fill_cnt_o    (fill_cnt),
      .scan_req_i    (scan_req),
      .scan_len_i    (scan_len),
      .scan_ack_o    (scan_ack),
      .scan_err_o    (scan_err),
      .rd_addr_o     (rd_addr),
      .rd_valid_o    (rd_valid),
      .rd_ready_i    (rd_ready),
      .rd_last_o     (rd_last),
      .scan_done_o   (scan_done),
      .overrun_o     (overrun),
      .busy_o        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic write_n(input int n);
      angle_valid = 1'b1;
      repeat (n) begin
         chk("buf_wr_addr", buf_wr_addr, m_wr);
         tick();
         m_wr = (m_wr + 1) % 256;
         if (m_fill < 256) m_fill++;
      end
      angle_valid = 1'b0;
      chk("wr_ptr", wr_ptr, m_wr);
      chk("fill_cnt", fill_cnt, m_fill);
   endtask

   task automatic run_scan(input int len, input logic [3:0] pat);
      int         cyc;
      logic [7:0] st;
      st = 8'((m_wr - len) & 255);
      scan_req = 1'b1;
      scan_len = 9'(len);
      tick();
      scan_req = 1'b0;
      chk("scan_ack", scan_ack, 1);
      chk("scan_err", scan_err, 0);
      chk("busy", busy, 1);
      for (int i = 0; i < len; i++) exp_q.push_back(8'((int'(st) + i) & 255));
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 4 * len + 16) begin
         rd_ready = pat[cyc % 4];
         #1;
         chk("rd_valid", rd_valid, 1);
         chk("rd_addr", rd_addr, exp_q[0]);
         chk("rd_last", rd_last, exp_q.size() == 1);
         if (rd_ready) void'(exp_q.pop_front());
         tick();
         cyc++;
      end
      rd_ready = 1'b0;
      if (exp_q.size() != 0) begin
         chk("scan_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
      chk("scan_done", scan_done, 1);
      chk("rd_valid_done", rd_valid, 0);
      chk("busy_done", busy, 0);
      tick();
      chk("scan_done_pulse", scan_done, 0);
   endtask

   task automatic req_reject(input int len);
      scan_req = 1'b1;
      scan_len = 9'(len);
      tick();
      scan_req = 1'b0;
      chk("rej_err", scan_err, 1);
      chk("rej_ack", scan_ack, 0);
      chk("rej_busy", busy, 0);
      tick();
      chk("rej_err_pulse", scan_err, 0);
      chk("rej_busy2", busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      frame_start = 1'b0;
      angle_valid = 1'b0;
      scan_req    = 1'b0;
      scan_len    = '0;
      rd_ready    = 1'b0;
      repeat (3) tick();
      chk("rst_wr_ptr", wr_ptr, 0);
      chk("rst_fill", fill_cnt, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      tick();

      // Fill 10, scan the last 4: addresses 6..9
      write_n(10);
      run_scan(4, 4'b1111);

      // Rejected requests: empty window and window larger than fill
      req_reject(0);
      req_reject(11);

      // Backpressure 1,0,0,1 (bit0 first) on a length-3 scan: 7,8,9
      run_scan(3, 4'b1001);

      // Reset while a scan is outstanding
      scan_req = 1'b1;
      scan_len = 9'd2;
      tick();
      scan_req = 1'b0;
      chk("mid_ack", scan_ack, 1);
      chk("mid_rd_valid", rd_valid, 1);
      rst = 1'b1;
      #1;
      chk("arst_rd_valid", rd_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_ack", scan_ack, 0);
      chk("arst_last", rd_last, 0);
      chk("arst_wr_ptr", wr_ptr, 0);
      chk("arst_fill", fill_cnt, 0);
      chk("arst_rd_addr", rd_addr, 0);
      tick();
      rst = 1'b0;
      m_wr = 0;
      m_fill = 0;
      tick();
      scan_req = 1'b1;
      scan_len = 9'd1;
      tick();
      scan_req = 1'b0;
      chk("idle_ack", scan_ack, 0);
      chk("idle_err", scan_err, 0);
      chk("idle_busy", busy, 0);

      // 300 writes wrap the pointer to 44 and saturate fill at 256
      write_n(300);
      run_scan(256, 4'b1111);
      chk("fill_after_full", fill_cnt, 256);

      // Full-window scan stalled, one write overwrites the oldest entry
      scan_req = 1'b1;
      scan_len = 9'd256;
      tick();
      scan_req = 1'b0;
      chk("ovr_ack", scan_ack, 1);
      chk("ovr_pre", overrun, 0);
      angle_valid = 1'b1;
      tick();
      angle_valid = 1'b0;
      chk("ovr_set", overrun, 1);
      chk("ovr_rd_addr_hold", rd_addr, 8'(m_wr));
      chk("ovr_rd_valid", rd_valid, 1);
      m_wr = (m_wr + 1) % 256;
      chk("ovr_fill", fill_cnt, 256);

      // Frame start with same-cycle sample aborts the scan
      frame_start = 1'b1;
      angle_valid = 1'b1;
      #1;
      chk("fs_wr_addr", buf_wr_addr, 0);
      chk("fs_wr_en", buf_wr_en, 1);
      tick();
      frame_start = 1'b0;
      angle_valid = 1'b0;
      chk("fs_wr_ptr", wr_ptr, 1);
      chk("fs_fill", fill_cnt, 1);
      chk("fs_overrun", overrun, 0);
      chk("fs_rd_valid", rd_valid, 0);
      chk("fs_busy", busy, 0);
      chk("fs_done", scan_done, 0);
      tick();
      chk("fs_done2", scan_done, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
